// File: rtl/fft_pkg.sv
// Shared constants, sample type and packed-bus helpers for the 8-point FFT datapath.
package fft_pkg;

    localparam int unsigned FFT_N  = 8;
    localparam int unsigned FFT_DW = 16;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    // LSB position of slot k on a bus of dw-wide slots.
    function automatic int unsigned slice_lsb(input int unsigned k, input int unsigned dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// N-slot complex register bank: single-slot write, async clear, whole-frame packed read-out.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int unsigned DW = FFT_DW,
    parameter int unsigned N  = FFT_N,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wr_re,
    input  logic [DW-1:0] wr_im,
    output logic [N*DW-1:0] rd_re,
    output logic [N*DW-1:0] rd_im
);

    logic [N-1:0][DW-1:0] re_q, re_d;
    logic [N-1:0][DW-1:0] im_q, im_d;

    always_comb begin
        re_d = re_q;
        im_d = im_q;
        if (we) begin
            re_d[addr] = wr_re;
            im_d[addr] = wr_im;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_q <= '0;
            im_q <= '0;
        end else begin
            re_q <= re_d;
            im_q <= im_d;
        end
    end

    always_comb begin
        rd_re = '0;
        rd_im = '0;
        for (int unsigned k = 0; k < N; k++) begin
            rd_re[slice_lsb(k, DW) +: DW] = re_q[k];
            rd_im[slice_lsb(k, DW) +: DW] = im_q[k];
        end
    end

endmodule

// File: rtl/fft8_input_framer.sv
// Serial-to-parallel framer: ping-pong buffers natural-order samples into N-sample frames for
// the FFT core, with start-of-frame resync and a handed-off frame counter.
module fft8_input_framer
    import fft_pkg::*;
#(
    parameter int unsigned DW = FFT_DW,
    parameter int unsigned N  = FFT_N,
    parameter int unsigned CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_sop,
    input  logic [DW-1:0]   s_re,
    input  logic [DW-1:0]   s_im,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [N*DW-1:0] m_re,
    output logic [N*DW-1:0] m_im,
    output logic            err_resync,
    output logic [CW-1:0]   frame_cnt
);

    localparam int unsigned AW = $clog2(N);

    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic          err_q, err_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;

    logic          accept;
    logic          handoff;
    logic [AW-1:0] wr_slot;
    logic [N*DW-1:0] bank0_re, bank0_im, bank1_re, bank1_im;

    assign s_ready    = !full_q[wr_bank_q];
    assign m_valid    = full_q[rd_bank_q];
    assign accept     = s_valid && s_ready;
    assign handoff    = m_valid && m_ready;
    assign err_resync = err_q;
    assign frame_cnt  = frame_cnt_q;
    assign m_re       = rd_bank_q ? bank1_re : bank0_re;
    assign m_im       = rd_bank_q ? bank1_im : bank0_im;

    // Write and read banks differ whenever both events fire, so full bits never collide.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        wr_slot     = wr_cnt_q;
        if (handoff) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            frame_cnt_d       = frame_cnt_q + CW'(1);
        end
        if (accept) begin
            if (s_sop && (wr_cnt_q != '0)) begin
                wr_slot  = '0;
                wr_cnt_d = AW'(1);
                err_d    = 1'b1;
            end else if (wr_cnt_q == AW'(N - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    fft_frame_bank #(.DW(DW), .N(N), .AW(AW)) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (accept && !wr_bank_q),
        .addr  (wr_slot),
        .wr_re (s_re),
        .wr_im (s_im),
        .rd_re (bank0_re),
        .rd_im (bank0_im)
    );

    fft_frame_bank #(.DW(DW), .N(N), .AW(AW)) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (accept && wr_bank_q),
        .addr  (wr_slot),
        .wr_re (s_re),
        .wr_im (s_im),
        .rd_re (bank1_re),
        .rd_im (bank1_im)
    );

endmodule
